// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the signals between the 5-stage pipeline and hazard_ctrl_unit.
//   master: pipeline side (drives register indices/enables, receives controls)
//   slave : hazard_ctrl_unit side
//   Parameters: REG_AW register-index width, SCNT_W stall-counter width
//   Inputs to the unit : Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
//                        RegWriteE/M/W, LoadE, PCSrcE, MemBusyM
//   Outputs of the unit: ForwardAE, ForwardBE, StallF..StallW, FlushD, FlushE, StallCnt
//   BRANCH_FWD_EN adds BranchD and LoadM (Decode-branch hazard inputs) and
//   ForwardAD/ForwardBD (Decode-branch compare forwarding).
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int SCNT_W = 16
);
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              LoadE, PCSrcE, MemBusyM;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, StallM, StallW;
    logic              FlushD, FlushE;
    logic [SCNT_W-1:0] StallCnt;
`ifdef BRANCH_FWD_EN
    logic              BranchD, LoadM;
    logic              ForwardAD, ForwardBD;
`endif

    modport master (
`ifdef BRANCH_FWD_EN
        output BranchD, LoadM,
        input  ForwardAD, ForwardBD,
`endif
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemBusyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  StallCnt
    );

    modport slave (
`ifdef BRANCH_FWD_EN
        input  BranchD, LoadM,
        output ForwardAD, ForwardBD,
`endif
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemBusyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output StallCnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard controller for a 5-stage RISC-V pipeline: EX operand forwarding
//   from MEM/WB, load-use stall sequencing (LU_CYC bubbles), whole-pipe freeze
//   while data memory is busy, wrong-path flush on taken branch/jump, and a
//   saturating count of cycles with StallF asserted.
//   Ports: clk, rst (synchronous, active high), hz (hazard_ctrl_if.slave).
//   The interface instance must use the same REG_AW/SCNT_W as this module.
//   Optional macro BRANCH_FWD_EN: Decode-stage branch forwarding
//   (ForwardAD/ForwardBD) and one-cycle Decode-branch dependency stalls.
module hazard_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int LU_CYC = 1,
    parameter int SCNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam logic [SCNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]        LU_LOAD = 3'(LU_CYC - 1);

    state_t            state, stateNext;
    logic [2:0]        luCnt, luCntNext;
    logic [SCNT_W-1:0] stallCnt;
    logic              luHazard;
    logic              stallF, stallD, stallE, stallM, stallW, flushD, flushE;
    logic [1:0]        fwdA, fwdB;

    // MEM result beats WB result; x0 is never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic              regWriteM,
        input logic [REG_AW-1:0] rdM,
        input logic              regWriteW,
        input logic [REG_AW-1:0] rdW
    );
        if (rs == REG_AW'(0))             return 2'b00;
        else if (regWriteM && rdM == rs)  return 2'b10;
        else if (regWriteW && rdW == rs)  return 2'b01;
        else                              return 2'b00;
    endfunction

    always_comb begin
        luHazard = hz.LoadE && hz.RegWriteE && (hz.RdE != REG_AW'(0)) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    end

`ifdef BRANCH_FWD_EN
    // LoadM is the extra input that tells a load sitting in MEM apart
    // from an ALU result that can already be forwarded to Decode.
    logic brHazard;
    always_comb begin
        brHazard = hz.BranchD && (
            (hz.RegWriteE && (hz.RdE != REG_AW'(0)) &&
             ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D))) ||
            (hz.LoadM && (hz.RdM != REG_AW'(0)) &&
             ((hz.RdM == hz.Rs1D) || (hz.RdM == hz.Rs2D))));
    end
`endif

    always_comb begin
        stateNext = state;
        luCntNext = luCnt;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        stallW    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        unique case (state)
            RUN: begin
                if (hz.MemBusyM) begin
                    {stallF, stallD, stallE, stallM, stallW} = '1;
                    stateNext = MEM_WAIT;
                end else if (hz.PCSrcE) begin
                    // A load-use consumer in Decode is on the wrong path.
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (luHazard) begin
                    stallF    = 1'b1;
                    stallD    = 1'b1;
                    flushE    = 1'b1;
                    luCntNext = LU_LOAD;
                    stateNext = (LU_CYC > 1) ? LU_STALL : RUN;
                end
`ifdef BRANCH_FWD_EN
                else if (brHazard) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
`endif
            end
            LU_STALL: begin
                if (hz.MemBusyM) begin
                    {stallF, stallD, stallE, stallM, stallW} = '1;
                    stateNext = MEM_WAIT;
                end else begin
                    stallF    = 1'b1;
                    stallD    = 1'b1;
                    flushE    = 1'b1;
                    luCntNext = luCnt - 3'd1;
                    if (luCnt == 3'd1) stateNext = RUN;
                end
            end
            MEM_WAIT: begin
                {stallF, stallD, stallE, stallM, stallW} = '1;
                if (!hz.MemBusyM) stateNext = (luCnt != 3'd0) ? LU_STALL : RUN;
            end
            default: stateNext = RUN;
        endcase
        if (rst) begin
            {stallF, stallD, stallE, stallM, stallW, flushD, flushE} = '0;
        end
    end

    always_comb begin
        fwdA = '0;
        fwdB = '0;
        if (!rst) begin
            fwdA = fwdSel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
            fwdB = fwdSel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            luCnt    <= '0;
            stallCnt <= '0;
        end else begin
            state <= stateNext;
            luCnt <= luCntNext;
            if (stallF && stallCnt != CNT_MAX) stallCnt <= stallCnt + SCNT_W'(1);
        end
    end

    assign hz.ForwardAE = fwdA;
    assign hz.ForwardBE = fwdB;
    assign hz.StallF    = stallF;
    assign hz.StallD    = stallD;
    assign hz.StallE    = stallE;
    assign hz.StallM    = stallM;
    assign hz.StallW    = stallW;
    assign hz.FlushD    = flushD;
    assign hz.FlushE    = flushE;
    assign hz.StallCnt  = stallCnt;

`ifdef BRANCH_FWD_EN
    assign hz.ForwardAD = !rst && hz.RegWriteM && (hz.RdM != REG_AW'(0)) && (hz.RdM == hz.Rs1D);
    assign hz.ForwardBD = !rst && hz.RegWriteM && (hz.RdM != REG_AW'(0)) && (hz.RdM == hz.Rs2D);
`endif
endmodule
